// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 line step runner.
// Holds the FSM encoding, the last step index and the length width.
package motoro3_pkg;

  localparam int LEN_W = 16;
  localparam logic [3:0] STEP_LAST = 4'd15;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  // Zero lengths are treated as one so a step can never stall.
  function automatic len_t len_floor1(input len_t v);
    return (v == '0) ? len_t'(1) : v;
  endfunction

endpackage

// File: rtl/motoro3_pwm_period_cnt.sv
// PWM period / cycle counter pair with latched lengths.
// Flags the period wrap, the step end and the PWM high phase.
module motoro3_pwm_period_cnt
  import motoro3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [LEN_W-1:0] pl_len,
  input  logic [LEN_W-1:0] sl_len,
  output logic             step_end,
  output logic             pwm_hi
);

  len_t pl_reg;
  len_t sl_reg;
  len_t period_cnt;
  len_t cyc_cnt;
  logic wrap;

  assign wrap     = (period_cnt == pl_reg - len_t'(1));
  assign step_end = wrap && (cyc_cnt == sl_reg - len_t'(1));
  assign pwm_hi   = (period_cnt < (pl_reg >> 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pl_reg     <= '0;
      sl_reg     <= '0;
      period_cnt <= '0;
      cyc_cnt    <= '0;
    end else if (load) begin
      pl_reg     <= len_floor1(pl_len);
      sl_reg     <= len_floor1(sl_len);
      period_cnt <= '0;
      cyc_cnt    <= '0;
    end else if (en) begin
      if (wrap) begin
        period_cnt <= '0;
        cyc_cnt    <= cyc_cnt + len_t'(1);
      end else begin
        period_cnt <= period_cnt + len_t'(1);
      end
    end
  end

endmodule

// File: rtl/motoro3_line_step_runner.sv
// Runs a 16-step line: per step, load lengths then emit PWM periods.
// FSM lives here; period/cycle counting is in the counter sub-module.
module motoro3_line_step_runner
  import motoro3_pkg::*;
(
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3r_start,
  input  logic             m3r_stop,
  input  logic [LEN_W-1:0] plLen,
  input  logic [LEN_W-1:0] slLen,
  output logic [3:0]       lcStep,
  output logic             pwmOut,
  output logic             stepTick,
  output logic             lineBusy,
  output logic             lineDone
);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] step_q;
  logic [3:0] step_d;
  logic       busy_q;
  logic       load;
  logic       en;
  logic       step_end;
  logic       pwm_hi;
  logic       tick;
  logic       done;
  logic       pwm;

  motoro3_pwm_period_cnt u_cnt (
    .clk      (clk),
    .rst_n    (nRst),
    .load     (load),
    .en       (en),
    .pl_len   (plLen),
    .sl_len   (slLen),
    .step_end (step_end),
    .pwm_hi   (pwm_hi)
  );

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      busy_q  <= (state_d == ST_LOAD) || (state_d == ST_RUN);
    end
  end

  // Stop overrides everything, including its own cycle's outputs.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load    = 1'b0;
    en      = 1'b0;
    tick    = 1'b0;
    done    = 1'b0;
    pwm     = 1'b0;
    if (m3r_stop) begin
      state_d = ST_IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (m3r_start) begin
            state_d = ST_LOAD;
            step_d  = '0;
          end
        end
        ST_LOAD: begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          en  = 1'b1;
          pwm = pwm_hi;
          if (step_end) begin
            tick = 1'b1;
            if (step_q == STEP_LAST) begin
              state_d = ST_DONE;
            end else begin
              step_d  = step_q + 4'd1;
              state_d = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done    = 1'b1;
          step_d  = '0;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = '0;
        end
      endcase
    end
  end

  assign lcStep   = step_q;
  assign pwmOut   = pwm;
  assign stepTick = tick;
  assign lineBusy = busy_q;
  assign lineDone = done;

endmodule

// File: tb/tb_motoro3_line_step_runner.sv
// Self-checking bench for motoro3_line_step_runner.
// Table of line runs plus hand sequences for stop, reset and ignored starts.
module tb_motoro3_line_step_runner;

  logic        clk = 1'b0;
  logic        nRst;
  logic        m3r_start;
  logic        m3r_stop;
  logic [15:0] plLen;
  logic [15:0] slLen;
  logic [3:0]  lcStep;
  logic        pwmOut;
  logic        stepTick;
  logic        lineBusy;
  logic        lineDone;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  motoro3_line_step_runner dut (
    .clk       (clk),
    .nRst      (nRst),
    .m3r_start (m3r_start),
    .m3r_stop  (m3r_stop),
    .plLen     (plLen),
    .slLen     (slLen),
    .lcStep    (lcStep),
    .pwmOut    (pwmOut),
    .stepTick  (stepTick),
    .lineBusy  (lineBusy),
    .lineDone  (lineDone)
  );

  typedef struct {
    int pl;
    int sl;
    int mode;
    int exp_busy;
    int exp_done;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mode 0 plain, 1 extra start at step 3, 2 plLen 4->8 during step 2
  task automatic run_line(input vec_t v, input string tag);
    int ps[16];
    int ss[16];
    int tq[$];
    int acc;
    int k;
    int p;
    int d;
    int ep;
    int ebusy;
    int estep;
    int busy_cnt;
    int done_at;
    int perr;
    int berr;
    int serr;
    int terr;
    int extra;
    int t;
    int budget;
    int pe;
    int se;
    pe = (v.pl == 0) ? 1 : v.pl;
    se = (v.sl == 0) ? 1 : v.sl;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      ps[i] = (v.mode == 2 && i >= 3) ? 8 : pe;
      ss[i] = se;
      acc += 1 + ps[i] * ss[i];
      tq.push_back(acc);
    end
    plLen = 16'(v.pl);
    slLen = 16'(v.sl);
    m3r_start = 1'b1;
    @(posedge clk);
    #1 m3r_start = 1'b0;
    k = 0; p = 0; busy_cnt = 0; done_at = -1;
    perr = 0; berr = 0; serr = 0; terr = 0; extra = 0;
    budget = v.exp_done + 8;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      ep = 0;
      ebusy = 0;
      estep = 0;
      d = 1;
      if (k < 16) begin
        d = 1 + ps[k] * ss[k];
        ebusy = 1;
        estep = k;
        if (p != 0) ep = (((p - 1) % ps[k]) < (ps[k] >> 1)) ? 1 : 0;
      end else if (k == 16) begin
        estep = 15;
      end
      if (int'(pwmOut) != ep) perr++;
      if (int'(lineBusy) != ebusy) berr++;
      if (int'(lcStep) != estep) serr++;
      if (stepTick) begin
        if (tq.size() == 0) extra++;
        else begin
          t = tq.pop_front();
          if (t != n) terr++;
        end
      end
      if (lineDone) begin
        if (done_at < 0) done_at = n;
        else extra++;
      end
      if (lineBusy) busy_cnt++;
      if (k < 16) begin
        p++;
        if (p == d) begin
          k++;
          p = 0;
        end
      end else begin
        k++;
      end
      m3r_start = (v.mode == 1 && k == 3 && p == 2);
      if (v.mode == 2 && k == 2 && p == 3) plLen = 16'd8;
    end
    m3r_start = 1'b0;
    check({tag, "_ticks_left"}, tq.size(), 0);
    check({tag, "_tick_time_errs"}, terr, 0);
    check({tag, "_extra_pulses"}, extra, 0);
    check({tag, "_pwm_errs"}, perr, 0);
    check({tag, "_busy_errs"}, berr, 0);
    check({tag, "_step_errs"}, serr, 0);
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    check({tag, "_done_cycle"}, done_at, v.exp_done);
  endtask

  initial begin
    int found;
    vt[0] = '{pl: 4, sl: 2, mode: 0, exp_busy: 144, exp_done: 145};
    vt[1] = '{pl: 0, sl: 0, mode: 0, exp_busy: 32,  exp_done: 33};
    vt[2] = '{pl: 1, sl: 3, mode: 0, exp_busy: 64,  exp_done: 65};
    vt[3] = '{pl: 3, sl: 1, mode: 0, exp_busy: 64,  exp_done: 65};
    vt[4] = '{pl: 5, sl: 3, mode: 0, exp_busy: 256, exp_done: 257};
    vt[5] = '{pl: 4, sl: 2, mode: 1, exp_busy: 144, exp_done: 145};
    vt[6] = '{pl: 4, sl: 2, mode: 2, exp_busy: 248, exp_done: 249};

    nRst = 1'b0;
    m3r_start = 1'b0;
    m3r_stop = 1'b0;
    plLen = '0;
    slLen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {lcStep, pwmOut, stepTick, lineBusy, lineDone}, 0);
    nRst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_line(vt[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // stop on the step-5 tick: tick suppressed, then idle
    plLen = 16'd4;
    slLen = 16'd2;
    m3r_start = 1'b1;
    @(posedge clk);
    #1 m3r_start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      @(negedge clk);
      if (lcStep == 4'd5 && stepTick) found = 1;
    end
    check("stop_reached_step5", found, 1);
    m3r_stop = 1'b1;
    #1 check("stop_tick_suppressed", stepTick, 0);
    @(posedge clk);
    #1 m3r_stop = 1'b0;
    check("stop_state", {lcStep, lineBusy}, 0);
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (lineDone || lineBusy || stepTick) found++;
    end
    check("stop_stays_idle", found, 0);

    // start and stop together from idle: stop wins
    @(negedge clk);
    m3r_start = 1'b1;
    m3r_stop = 1'b1;
    @(posedge clk);
    #1 m3r_start = 1'b0;
    m3r_stop = 1'b0;
    check("start_stop_busy", lineBusy, 0);
    repeat (3) @(negedge clk);
    check("start_stop_idle", {lcStep, lineBusy, pwmOut}, 0);

    // reset mid-run at step 9, then restart on the first cycle
    plLen = 16'd4;
    slLen = 16'd2;
    m3r_start = 1'b1;
    @(posedge clk);
    #1 m3r_start = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      @(negedge clk);
      if (lcStep == 4'd9 && !stepTick) found = 1;
    end
    check("reset_reached_step9", found, 1);
    nRst = 1'b0;
    @(posedge clk);
    #1 check("midrun_reset_outputs",
             {lcStep, pwmOut, stepTick, lineBusy, lineDone}, 0);
    @(negedge clk);
    nRst = 1'b1;
    run_line(vt[0], "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
